// File: rtl/gray_conv_arbiter.sv
// gray_conv_arbiter: several requesters share one registered binary<->Gray converter.
// A round-robin arbiter grants at most one request per cycle into a single result
// slot. The slot drains and refills in the same cycle, so a ready consumer sees one
// result per cycle. Each result is tagged with the requester index and the direction.
module gray_conv_arbiter #(
    parameter  int NREQ  = 4,
    parameter  int WIDTH = 3,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ-1:0]       req_mode,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic                  rsp_mode,
    output logic [WIDTH-1:0]      rsp_data
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

    slot_state_t      state_q, state_d;
    logic [IDW-1:0]   rr_ptr;
    logic             grant_found;
    logic [IDW-1:0]   grant_id;
    logic             sel_mode;
    logic [WIDTH-1:0] sel_data;
    logic             can_accept;
    logic             accept;
    int               scan_idx;

    // Binary to Gray: each bit is the XOR of itself and its upper neighbour.
    function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Gray to binary: running XOR from the MSB downwards.
    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int k = WIDTH - 2; k >= 0; k--) begin
            b[k] = b[k+1] ^ g[k];
        end
        return b;
    endfunction

    // Round-robin search: first valid requester at or after rr_ptr, with wrap.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves one
        // unassigned and no latch is inferred.
        grant_found = 1'b0;
        grant_id    = '0;
        sel_mode    = 1'b0;
        sel_data    = '0;
        scan_idx    = 0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = (int'(rr_ptr) + k) % NREQ;
            if (!grant_found && req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_id    = IDW'(scan_idx);
                sel_mode    = req_mode[scan_idx];
                sel_data    = req_data[scan_idx*WIDTH +: WIDTH];
            end
        end
    end

    // Slot next-state and grant outputs; the slot can take a new result when empty
    // or when the current one is leaving this cycle.
    always_comb begin
        state_d    = state_q;
        req_ready  = '0;
        can_accept = (state_q == EMPTY) || rsp_ready;
        // Gating with rst_n keeps every grant low while reset is held.
        accept     = grant_found && can_accept && rst_n;
        if (accept) begin
            req_ready[grant_id] = 1'b1;
            state_d             = FULL;
        end else if (state_q == FULL && rsp_ready) begin
            state_d = EMPTY;
        end
    end

    assign rsp_valid = (state_q == FULL);

    // Slot state register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state is updated only with non-blocking assignments, so every
        // register samples pre-edge values regardless of block ordering.
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Result payload and round-robin pointer; both hold unless a grant is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_id   <= '0;
            rsp_mode <= 1'b0;
            rsp_data <= '0;
            rr_ptr   <= '0;
        end else if (accept) begin
            rsp_id   <= grant_id;
            rsp_mode <= sel_mode;
            rsp_data <= sel_mode ? gray2bin(sel_data) : bin2gray(sel_data);
            rr_ptr   <= IDW'((int'(grant_id) + 1) % NREQ);
        end
    end

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Bench for gray_conv_arbiter: directed scenarios followed by randomized traffic,
// all checked against a transaction-level model of the slot and the arbiter.
module tb_gray_conv_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 3;
    localparam int IDW   = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       req_mode;
    logic [NREQ*WIDTH-1:0] req_data;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic                  rsp_mode;
    logic [WIDTH-1:0]      rsp_data;

    int n_checks = 0;
    int n_bad    = 0;

    // Model state: pointer, slot occupancy, and slot payload.
    int              m_ptr   = 0;
    bit              m_valid = 1'b0;
    int              m_id    = 0;
    int              m_mode  = 0;
    int              m_data  = 0;
    logic [NREQ-1:0] exp_ready;

    gray_conv_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_mode  (req_mode),
        .req_data  (req_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_mode  (rsp_mode),
        .rsp_data  (rsp_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference conversion: b2g by definition, g2b as the inverse found by search.
    function automatic int conv_ref(input int mode, input int d);
        if (mode == 0) return d ^ (d >> 1);
        for (int b = 0; b < (1 << WIDTH); b++) begin
            if ((b ^ (b >> 1)) == d) return b;
        end
        return -1;
    endfunction

    function automatic int model_winner(input logic [NREQ-1:0] v);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        m_ptr   = 0;
        m_valid = 1'b0;
        m_id    = 0;
        m_mode  = 0;
        m_data  = 0;
    endfunction

    // One clock: compare grant and slot at the falling edge, then advance the model
    // across the rising edge, returning #1 after it.
    task automatic cycle();
        int w;
        bit can;
        @(negedge clk);
        w         = model_winner(req_valid);
        can       = !m_valid || rsp_ready;
        exp_ready = (w >= 0 && can) ? NREQ'(1 << w) : '0;
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("rsp_valid", 32'(rsp_valid), 32'(m_valid));
        check("rsp_id",    32'(rsp_id),    32'(m_id));
        check("rsp_mode",  32'(rsp_mode),  32'(m_mode));
        check("rsp_data",  32'(rsp_data),  32'(m_data));
        @(posedge clk);
        if (exp_ready != '0) begin
            m_valid = 1'b1;
            m_id    = w;
            m_mode  = int'(req_mode[w]);
            m_data  = conv_ref(m_mode, int'(req_data[w*WIDTH +: WIDTH]));
            m_ptr   = (w + 1) % NREQ;
        end else if (m_valid && rsp_ready) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    int rr_exp [6]  = '{0, 1, 2, 3, 0, 1};
    int b2g_tab [8] = '{0, 1, 3, 2, 6, 7, 5, 4};

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_mode  = '0;
        req_data  = '0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_data",  32'(rsp_data),  32'd0);
        rst_n = 1'b1;

        // Reset while FULL: fill the slot from req1 so rr_ptr moves off zero.
        req_data  = {3'b011, 3'b110, 3'b010, 3'b001};
        req_valid = 4'b0010;
        cycle();
        req_valid = 4'b1111;
        repeat (2) cycle();
        check("full_before_reset", 32'(rsp_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rsp_valid", 32'(rsp_valid), 32'd0);
        check("async_req_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b1;
        model_reset();

        // Round robin after reset starts at req0 and runs without bubbles.
        rsp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cycle();
            check("rr_valid", 32'(rsp_valid), 32'd1);
            check("rr_id",    32'(rsp_id),    32'(rr_exp[k]));
        end

        // Single b2g from req0.
        req_valid       = 4'b0001;
        req_mode[0]     = 1'b0;
        req_data[0 +: 3] = 3'b101;
        cycle();
        check("b2g_id",   32'(rsp_id),   32'd0);
        check("b2g_mode", 32'(rsp_mode), 32'd0);
        check("b2g_data", 32'(rsp_data), 32'b111);

        // Single g2b from req2, then drain to empty.
        req_valid        = 4'b0100;
        req_mode[2]      = 1'b1;
        req_data[6 +: 3] = 3'b111;
        cycle();
        check("g2b_id",   32'(rsp_id),   32'd2);
        check("g2b_mode", 32'(rsp_mode), 32'd1);
        check("g2b_data", 32'(rsp_data), 32'b101);
        req_valid = 4'b0000;
        cycle();
        check("drain_valid", 32'(rsp_valid), 32'd0);
        check("drain_hold",  32'(rsp_data),  32'b101);

        // Backpressure: req3 is next in line (pointer at 3).
        req_mode          = 4'b0000;
        req_data[9 +: 3]  = 3'b110;
        req_valid         = 4'b1111;
        cycle();
        check("bp_first_id", 32'(rsp_id), 32'd3);
        rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("bp_hold_id",   32'(rsp_id),   32'd3);
            check("bp_hold_data", 32'(rsp_data), 32'b101);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_grant", 32'(req_ready), 32'b0001);
        @(posedge clk);
        #1;
        // Mirror the grant taken across that edge into the model.
        m_valid = 1'b1;
        m_id    = 0;
        m_mode  = 0;
        m_data  = conv_ref(0, int'(req_data[0 +: 3]));
        m_ptr   = 1;
        check("bp_release_id", 32'(rsp_id), 32'd0);

        // Exhaustive conversion through req3 in both directions.
        req_valid = 4'b1000;
        for (int v = 0; v < 8; v++) begin
            req_mode[3]      = 1'b0;
            req_data[9 +: 3] = 3'(v);
            cycle();
            check("exh_b2g", 32'(rsp_data), 32'(b2g_tab[v]));
            req_mode[3]      = 1'b1;
            req_data[9 +: 3] = 3'(b2g_tab[v]);
            cycle();
            check("exh_g2b", 32'(rsp_data), 32'(v));
        end

        // Randomized traffic: a requester keeps its request until granted.
        req_valid = '0;
        exp_ready = '0;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (exp_ready[i] || !req_valid[i]) begin
                    req_valid[i]             = 1'($urandom_range(0, 1));
                    req_mode[i]              = 1'($urandom_range(0, 1));
                    req_data[i*WIDTH +: WIDTH] = 3'($urandom_range(0, 7));
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
